// File: rtl/pif_sram_slave.sv
// rtl/pif_sram_slave.sv - PIF slave that queues requests and runs them one at a time on a synchronous SRAM.
// Optional window/type error checking is enabled by defining PIF_SRAM_ERR_EN.
module pif_sram_slave #(
   parameter int          MEM_AW     = 14,
   parameter logic [31:0] BASE_ADDR  = 32'h6000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          READ_LAT   = 1
) (
   input  logic              CLK,
   input  logic              BReset,
   input  logic              POReqValid,
   output logic              PIReqRdy,
   input  logic [7:0]        POReqCntl,
   input  logic [31:0]       POReqAdrs,
   input  logic [31:0]       POReqData,
   input  logic [3:0]        POReqDataBE,
   input  logic [5:0]        POReqId,
   input  logic [1:0]        POReqPriority,
   output logic              PIRespValid,
   input  logic              PORespRdy,
   output logic [7:0]        PIRespCntl,
   output logic [31:0]       PIRespData,
   output logic [5:0]        PIRespId,
   output logic [1:0]        PIRespPriority,
   output logic              MemEn,
   output logic              MemWr,
   output logic [MEM_AW-1:0] MemAddr,
   output logic [3:0]        MemBE,
   output logic [31:0]       MemWrData,
   input  logic [31:0]       MemRdData
);

   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [7:0] RESP_RD_OK  = 8'h01;
   localparam logic [7:0] RESP_WR_OK  = 8'h11;
   localparam logic [7:0] RESP_RD_ERR = 8'h03;
   localparam logic [7:0] RESP_WR_ERR = 8'h13;

   typedef struct packed {
      logic [7:0]  cntl;
      logic [31:0] adrs;
      logic [31:0] data;
      logic [3:0]  be;
      logic [5:0]  id;
      logic [1:0]  prio;
   } req_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   req_t        fifo_mem [FIFO_DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [PW:0] wr_ptr_nxt;
   logic [PW:0] rd_ptr_nxt;
   logic        fifo_empty;
   logic        full_nxt;
   logic        push;
   logic        pop;
   req_t        head;
   req_t        req_in;
   logic        head_wr;
   logic        head_err;
   logic        unused_bits;

   state_t      state;
   logic [1:0]  lat_cnt;

   assign req_in = '{cntl: POReqCntl, adrs: POReqAdrs, data: POReqData,
                     be: POReqDataBE, id: POReqId, prio: POReqPriority};

   assign head       = fifo_mem[rd_ptr[PW-1:0]];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign push       = POReqValid & PIReqRdy;
   assign pop        = (state == ST_IDLE) && !fifo_empty;
   assign wr_ptr_nxt = wr_ptr + (PW+1)'(push);
   assign rd_ptr_nxt = rd_ptr + (PW+1)'(pop);
   assign full_nxt   = (wr_ptr_nxt[PW] != rd_ptr_nxt[PW]) &&
                       (wr_ptr_nxt[PW-1:0] == rd_ptr_nxt[PW-1:0]);

   // Ready is computed from the post-edge pointers so a pop never reaches it combinationally.
   always_ff @(posedge CLK or posedge BReset) begin
      if (BReset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         PIReqRdy <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         PIReqRdy <= !full_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr[PW-1:0]] <= req_in;
      end
   end

   assign head_wr = head.cntl[7];

`ifdef PIF_SRAM_ERR_EN
   assign head_err = (head.adrs[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]) ||
                     ((head.cntl != 8'h00) && (head.cntl != 8'h80));
`else
   assign head_err = 1'b0;
`endif

   assign unused_bits = ^{head.adrs[1:0], head.adrs[31:MEM_AW+2], head.cntl[6:0]};

   // The SRAM sees the FIFO head in the same cycle it is popped.
   assign MemEn     = pop && !head_err;
   assign MemWr     = MemEn && head_wr;
   assign MemAddr   = head.adrs[MEM_AW+1:2];
   assign MemBE     = head_wr ? head.be : 4'hF;
   assign MemWrData = head.data;

   always_ff @(posedge CLK or posedge BReset) begin
      if (BReset) begin
         state          <= ST_IDLE;
         lat_cnt        <= 2'd0;
         PIRespValid    <= 1'b0;
         PIRespCntl     <= 8'h00;
         PIRespData     <= 32'h0;
         PIRespId       <= 6'h0;
         PIRespPriority <= 2'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  PIRespId       <= head.id;
                  PIRespPriority <= head.prio;
                  PIRespData     <= 32'h0;
                  if (head_err) begin
                     PIRespCntl  <= head_wr ? RESP_WR_ERR : RESP_RD_ERR;
                     PIRespValid <= 1'b1;
                     state       <= ST_RESP;
                  end else if (head_wr) begin
                     PIRespCntl  <= RESP_WR_OK;
                     PIRespValid <= 1'b1;
                     state       <= ST_RESP;
                  end else begin
                     PIRespCntl  <= RESP_RD_OK;
                     lat_cnt     <= 2'd0;
                     state       <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (lat_cnt == 2'(READ_LAT - 1)) begin
                  PIRespData  <= MemRdData;
                  PIRespValid <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            ST_RESP: begin
               if (PORespRdy) begin
                  PIRespValid <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pif_sram_slave.sv
// tb/tb_pif_sram_slave.sv - directed vector bench for pif_sram_slave with a READ_LAT=1 SRAM model.
// Error-response vectors switch on PIF_SRAM_ERR_EN.
module tb_pif_sram_slave;

   localparam int MEM_AW   = 14;
   localparam int READ_LAT = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_rdy;
   logic [7:0]        req_cntl = 8'h00;
   logic [31:0]       req_adrs = 32'h0;
   logic [31:0]       req_data = 32'h0;
   logic [3:0]        req_be = 4'h0;
   logic [5:0]        req_id = 6'h0;
   logic [1:0]        req_prio = 2'h0;
   logic              resp_valid;
   logic              resp_rdy = 1'b0;
   logic [7:0]        resp_cntl;
   logic [31:0]       resp_data;
   logic [5:0]        resp_id;
   logic [1:0]        resp_prio;
   logic              mem_en;
   logic              mem_wr;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wr_data;
   logic [31:0]       mem_rd_data = 32'h0;

   int checks = 0;
   int failures = 0;

   pif_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(32'h6000_0000), .FIFO_DEPTH(4), .READ_LAT(READ_LAT)) dut (
      .CLK(clk), .BReset(rst),
      .POReqValid(req_valid), .PIReqRdy(req_rdy), .POReqCntl(req_cntl), .POReqAdrs(req_adrs),
      .POReqData(req_data), .POReqDataBE(req_be), .POReqId(req_id), .POReqPriority(req_prio),
      .PIRespValid(resp_valid), .PORespRdy(resp_rdy), .PIRespCntl(resp_cntl), .PIRespData(resp_data),
      .PIRespId(resp_id), .PIRespPriority(resp_prio),
      .MemEn(mem_en), .MemWr(mem_wr), .MemAddr(mem_addr), .MemBE(mem_be),
      .MemWrData(mem_wr_data), .MemRdData(mem_rd_data)
   );

   always #5 clk = ~clk;

   logic [31:0] sram [0:(1<<MEM_AW)-1];
   logic [31:0] merge_w;
   initial for (int i = 0; i < (1<<MEM_AW); i++) sram[i] = 32'h0;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) begin
            merge_w = sram[mem_addr];
            for (int b = 0; b < 4; b++) if (mem_be[b]) merge_w[b*8 +: 8] = mem_wr_data[b*8 +: 8];
            sram[mem_addr] <= merge_w;
         end else begin
            mem_rd_data <= sram[mem_addr];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0]  cntl;
      logic [31:0] adrs;
      logic [31:0] data;
      logic [3:0]  be;
      logic [5:0]  id;
      logic [1:0]  prio;
      logic [7:0]  exp_cntl;
      logic [31:0] exp_data;
      logic        exp_en;
      logic [13:0] exp_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [5:0] id, input logic [1:0] pr, input logic [7:0] ec, input logic [31:0] ed,
                      input logic en, input logic [13:0] ea);
      vec_t v;
      v.cntl = c; v.adrs = a; v.data = d; v.be = be; v.id = id; v.prio = pr;
      v.exp_cntl = ec; v.exp_data = ed; v.exp_en = en; v.exp_addr = ea;
      vecs.push_back(v);
   endtask

   task automatic drive_req(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [5:0] id, input logic [1:0] pr);
      req_valid = 1'b1; req_cntl = c; req_adrs = a; req_data = d; req_be = be; req_id = id; req_prio = pr;
   endtask

   task automatic wait_rdy(input string name);
      int n = 0;
      while (!req_rdy && n < 40) begin step(); n++; end
      if (!req_rdy) check({name, "_rdy_timeout"}, 32'(req_rdy), 32'd1);
   endtask

   task automatic apply(input vec_t v, input int idx);
      int lat = 0;
      logic saw_en = 1'b0;
      logic is_rd;
      drive_req(v.cntl, v.adrs, v.data, v.be, v.id, v.prio);
      wait_rdy($sformatf("v%0d", idx));
      step();
      req_valid = 1'b0;
      check($sformatf("v%0d_mem_en", idx), 32'(mem_en), 32'(v.exp_en));
      if (v.exp_en) begin
         check($sformatf("v%0d_mem_wr", idx), 32'(mem_wr), 32'(v.cntl[7]));
         check($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
         check($sformatf("v%0d_mem_be", idx), 32'(mem_be), v.cntl[7] ? 32'(v.be) : 32'hF);
      end
      while (!resp_valid && lat < 20) begin
         step();
         lat++;
         if (mem_en) saw_en = 1'b1;
      end
      is_rd = v.exp_en && !v.cntl[7];
      check($sformatf("v%0d_latency", idx), 32'(lat), is_rd ? 32'(1 + READ_LAT) : 32'd1);
      check($sformatf("v%0d_extra_mem_en", idx), 32'(saw_en), 32'd0);
      check($sformatf("v%0d_cntl", idx), 32'(resp_cntl), 32'(v.exp_cntl));
      check($sformatf("v%0d_data", idx), resp_data, v.exp_data);
      check($sformatf("v%0d_id", idx), 32'(resp_id), 32'(v.id));
      check($sformatf("v%0d_prio", idx), 32'(resp_prio), 32'(v.prio));
      resp_rdy = 1'b1;
      step();
      resp_rdy = 1'b0;
      check($sformatf("v%0d_valid_clear", idx), 32'(resp_valid), 32'd0);
   endtask

   logic [5:0]  got_id   [8];
   logic [7:0]  got_cntl [8];
   logic [31:0] got_data [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(); step();
      check("rst_req_rdy", 32'(req_rdy), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_cntl", 32'(resp_cntl), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_req_rdy", 32'(req_rdy), 32'd1);

      add(8'h80, 32'h6000_0010, 32'hDEAD_BEEF, 4'hF, 6'd5,  2'd1, 8'h11, 32'h0,         1'b1, 14'h0004);
      add(8'h00, 32'h6000_0010, 32'h0,         4'h0, 6'd9,  2'd2, 8'h01, 32'hDEAD_BEEF, 1'b1, 14'h0004);
      add(8'h80, 32'h6000_0010, 32'h0000_1234, 4'h3, 6'd10, 2'd0, 8'h11, 32'h0,         1'b1, 14'h0004);
      add(8'h00, 32'h6000_0010, 32'h0,         4'h0, 6'd11, 2'd3, 8'h01, 32'hDEAD_1234, 1'b1, 14'h0004);
      add(8'h80, 32'h6000_FFFC, 32'hA5A5_5A5A, 4'hF, 6'd63, 2'd0, 8'h11, 32'h0,         1'b1, 14'h3FFF);
      add(8'h00, 32'h6000_FFFC, 32'h0,         4'h0, 6'd0,  2'd1, 8'h01, 32'hA5A5_5A5A, 1'b1, 14'h3FFF);
      add(8'h80, 32'h6000_0000, 32'h1122_3344, 4'hC, 6'd1,  2'd2, 8'h11, 32'h0,         1'b1, 14'h0000);
      add(8'h00, 32'h6000_0000, 32'h0,         4'h0, 6'd2,  2'd3, 8'h01, 32'h1122_0000, 1'b1, 14'h0000);
`ifdef PIF_SRAM_ERR_EN
      add(8'h00, 32'h7000_0000, 32'h0,         4'h0, 6'd3,  2'd0, 8'h03, 32'h0,         1'b0, 14'h0000);
      add(8'h40, 32'h6000_0010, 32'h0,         4'h0, 6'd4,  2'd1, 8'h03, 32'h0,         1'b0, 14'h0000);
      add(8'h80, 32'h5FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 6'd6,  2'd2, 8'h13, 32'h0,         1'b0, 14'h0000);
      add(8'h00, 32'h6001_0000, 32'h0,         4'h0, 6'd7,  2'd3, 8'h03, 32'h0,         1'b0, 14'h0000);
`else
      add(8'h00, 32'h7000_0000, 32'h0,         4'h0, 6'd3,  2'd0, 8'h01, 32'h1122_0000, 1'b1, 14'h0000);
      add(8'h40, 32'h6000_0010, 32'h0,         4'h0, 6'd4,  2'd1, 8'h01, 32'hDEAD_1234, 1'b1, 14'h0004);
      add(8'h80, 32'h5FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 6'd6,  2'd2, 8'h11, 32'h0,         1'b1, 14'h3FFF);
      add(8'h00, 32'h6001_0000, 32'h0,         4'h0, 6'd7,  2'd3, 8'h01, 32'h1122_0000, 1'b1, 14'h0000);
`endif
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Backpressure: one request parked in RESP, four more fill the FIFO
      resp_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_req(8'h80, 32'h6000_0100 + 32'(4*k), 32'hC0DE_0000 + 32'(k), 4'hF, 6'(20 + k), 2'd1);
         wait_rdy($sformatf("bp%0d", k));
         step();
      end
      req_valid = 1'b0;
      check("bp_full_rdy", 32'(req_rdy), 32'd0);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_head_id", 32'(resp_id), 32'd20);
      step(); step(); step();
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_id", 32'(resp_id), 32'd20);
      check("bp_hold_cntl", 32'(resp_cntl), 32'h11);
      resp_rdy = 1'b1;
      begin
         int got = 0;
         int n = 0;
         while (got < 5 && n < 60) begin
            if (resp_valid) begin
               check($sformatf("bp_order%0d", got), 32'(resp_id), 32'(20 + got));
               got++;
            end
            step();
            n++;
         end
         check("bp_count", 32'(got), 32'd5);
      end
      check("bp_rdy_back", 32'(req_rdy), 32'd1);

      // Back-to-back alternating write/read with response ready held high
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               if (k % 2 == 0)
                  drive_req(8'h80, 32'h6000_0400 + 32'(4*(k/2)), 32'h5A00_0000 + 32'(k/2) * 32'h111, 4'hF, 6'(40 + k), 2'd2);
               else
                  drive_req(8'h00, 32'h6000_0400 + 32'(4*(k/2)), 32'h0, 4'h0, 6'(40 + k), 2'd2);
               wait_rdy($sformatf("b2b%0d", k));
               step();
            end
            req_valid = 1'b0;
         end
         begin
            int got = 0;
            int n = 0;
            while (got < 8 && n < 200) begin
               if (resp_valid) begin
                  got_id[got] = resp_id; got_cntl[got] = resp_cntl; got_data[got] = resp_data;
                  got++;
               end
               step();
               n++;
            end
            check("b2b_count", 32'(got), 32'd8);
         end
      join
      for (int k = 0; k < 8; k++) begin
         check($sformatf("b2b_id%0d", k), 32'(got_id[k]), 32'(40 + k));
         check($sformatf("b2b_cntl%0d", k), 32'(got_cntl[k]), (k % 2 == 0) ? 32'h11 : 32'h01);
         if (k % 2 == 1)
            check($sformatf("b2b_data%0d", k), got_data[k], 32'h5A00_0000 + 32'(k/2) * 32'h111);
      end
      resp_rdy = 1'b0;
      step();

      // Reset while a read sits in WAIT with a second request queued
      drive_req(8'h00, 32'h6000_0010, 32'h0, 4'h0, 6'd7, 2'd0);
      wait_rdy("rw0");
      step();
      check("rw_mem_en_pre", 32'(mem_en), 32'd1);
      drive_req(8'h00, 32'h6000_0000, 32'h0, 4'h0, 6'd8, 2'd0);
      step();
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rw_resp_valid", 32'(resp_valid), 32'd0);
      check("rw_mem_en", 32'(mem_en), 32'd0);
      check("rw_req_rdy", 32'(req_rdy), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("rw_rdy_after", 32'(req_rdy), 32'd1);

      // Reset during the combinational SRAM strobe drops it at once
      drive_req(8'h80, 32'h6000_0200, 32'hFFFF_FFFF, 4'hF, 6'd12, 2'd0);
      step();
      req_valid = 1'b0;
      check("rs_mem_en_pre", 32'(mem_en), 32'd1);
      rst = 1'b1;
      #1;
      check("rs_mem_en", 32'(mem_en), 32'd0);
      step();
      rst = 1'b0;
      resp_rdy = 1'b1;
      begin
         logic saw_v = 1'b0;
         logic saw_e = 1'b0;
         for (int i = 0; i < 6; i++) begin
            step();
            if (resp_valid) saw_v = 1'b1;
            if (mem_en) saw_e = 1'b1;
         end
         check("rs_no_resp", 32'(saw_v), 32'd0);
         check("rs_no_mem_en", 32'(saw_e), 32'd0);
      end
      resp_rdy = 1'b0;
      check("rs_sram_untouched", sram[14'h0080], 32'h0);

      begin
         vec_t v;
         v.cntl = 8'h00; v.adrs = 32'h6000_0010; v.data = 32'h0; v.be = 4'h0; v.id = 6'd33; v.prio = 2'd3;
         v.exp_cntl = 8'h01; v.exp_data = 32'hDEAD_1234; v.exp_en = 1'b1; v.exp_addr = 14'h0004;
         apply(v, 99);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
